key_event_gen: RTL and testbench

KEY_EVENT_GEN -- requirements
Module: key_event_gen

---
 rtl/key_event_gen_pkg.sv | 22 ++
 rtl/key_channel.sv | 134 +++++++++++++
 rtl/key_event_gen.sv | 60 ++++++
 tb/tb_key_event_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_event_gen_pkg.sv
// Shared types and default timing for the key event generator.
// No logic; imported by key_channel and key_event_gen.
package key_event_gen_pkg;

    typedef enum logic [1:0] {
        KS_RELEASED = 2'd0,
        KS_PRESSED  = 2'd1,
        KS_HOLD     = 2'd2
    } key_state_t;

    localparam int NUM_KEYS         = 8;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 20;
    localparam int DEF_LONG_TICKS   = 800;
    localparam int DEF_REPEAT_TICKS = 200;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop sync, tick-sampled debounce, press/hold/repeat FSM.
// Latency: 2 clk sync + STABLE_TICKS ticks to level change; all outputs registered.
// Backpressure: none; event outputs are single-cycle pulses.
module key_channel
    import key_event_gen_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_raw,
    output logic level,
    output logic press_pls,
    output logic release_pls,
    output logic long_pls,
    output logic repeat_pls
);

    localparam int SW     = cnt_w(STABLE_TICKS);
    localparam int HOLD_N = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW     = cnt_w(HOLD_N);

    logic          sync_q1;
    logic          sync_q2;
    logic [SW-1:0] stb_cnt;
    logic          differ;
    logic          stb_hit;
    logic          acc_press;
    logic          acc_release;

    key_state_t    state;
    key_state_t    state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic          long_nxt;
    logic          repeat_nxt;

    assign differ      = (sync_q2 != level);
    assign stb_hit     = tick && differ && (stb_cnt == SW'(STABLE_TICKS - 1));
    assign acc_press   = stb_hit && level;
    assign acc_release = stb_hit && !level;

    // Any sample matching the current level restarts the run, so bounce never leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            stb_cnt <= '0;
            level   <= 1'b1;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
            if (tick) begin
                if (!differ) begin
                    stb_cnt <= '0;
                end else if (stb_hit) begin
                    level   <= sync_q2;
                    stb_cnt <= '0;
                end else begin
                    stb_cnt <= stb_cnt + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= KS_RELEASED;
            hold_cnt    <= '0;
            press_pls   <= 1'b0;
            release_pls <= 1'b0;
            long_pls    <= 1'b0;
            repeat_pls  <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            press_pls   <= acc_press;
            release_pls <= acc_release;
            long_pls    <= long_nxt;
            repeat_pls  <= repeat_nxt;
        end
    end

    // Release is checked before the hold threshold so it wins a same-tick collision.
    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        case (state)
            KS_RELEASED: begin
                if (acc_press) begin
                    state_nxt = KS_PRESSED;
                    hold_nxt  = '0;
                end
            end
            KS_PRESSED: begin
                if (acc_release) begin
                    state_nxt = KS_RELEASED;
                    hold_nxt  = '0;
                end else if (tick) begin
                    if (hold_cnt == HW'(LONG_TICKS - 1)) begin
                        state_nxt = KS_HOLD;
                        hold_nxt  = '0;
                        long_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
            end
            KS_HOLD: begin
                if (acc_release) begin
                    state_nxt = KS_RELEASED;
                    hold_nxt  = '0;
                end else if (tick) begin
                    if (hold_cnt == HW'(REPEAT_TICKS - 1)) begin
                        hold_nxt   = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
            end
            default: begin
                state_nxt = KS_RELEASED;
                hold_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_event_gen.sv
// Eight-key debouncer with press/release/long/repeat event pulses.
// Latency: 2 clk + STABLE_TICKS ticks from raw edge to key_press (up to one tick jitter).
// Backpressure: none; consumers must catch single-cycle pulses.
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keys,
    output logic [7:0] key_level,
    output logic [7:0] key_press,
    output logic [7:0] key_release,
    output logic [7:0] key_long,
    output logic [7:0] key_repeat,
    output logic       any_pressed
);

    localparam int TW = cnt_w(TICK_DIV);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_key_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .key_raw     (keys[i]),
            .level       (key_level[i]),
            .press_pls   (key_press[i]),
            .release_pls (key_release[i]),
            .long_pls    (key_long[i]),
            .repeat_pls  (key_repeat[i])
        );
    end

    assign any_pressed = ~&key_level;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with TICK_DIV=4, STABLE=3, LONG=10, REPEAT=4.
module tb_key_event_gen;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] keys;
    logic [7:0] key_level;
    logic [7:0] key_press;
    logic [7:0] key_release;
    logic [7:0] key_long;
    logic [7:0] key_repeat;
    logic       any_pressed;

    key_event_gen #(
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .LONG_TICKS   (10),
        .REPEAT_TICKS (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys        (keys),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat),
        .any_pressed (any_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event monitor: counts pulses and remembers when they happened.
    int cyc = 0;
    bit clr = 1'b0;
    int press_cnt[8], rel_cnt[8], long_cnt[8], rpt_cnt[8], both_cnt[8];
    int press_cyc[8], rel_cyc[8], long_cyc[8], first_rpt_cyc[8], last_rpt_cyc[8];
    bit seen_18 = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (clr) begin
            for (int b = 0; b < 8; b++) begin
                press_cnt[b] = 0; rel_cnt[b] = 0; long_cnt[b] = 0;
                rpt_cnt[b] = 0; both_cnt[b] = 0;
            end
            seen_18 = 1'b0;
        end else if (rst_n) begin
            for (int b = 0; b < 8; b++) begin
                if (key_press[b])   begin press_cnt[b]++; press_cyc[b] = cyc; end
                if (key_release[b]) begin rel_cnt[b]++;   rel_cyc[b]   = cyc; end
                if (key_long[b])    begin long_cnt[b]++;  long_cyc[b]  = cyc; end
                if (key_repeat[b]) begin
                    if (rpt_cnt[b] == 0) first_rpt_cyc[b] = cyc;
                    last_rpt_cyc[b] = cyc;
                    rpt_cnt[b]++;
                end
                if (key_press[b] && key_release[b]) both_cnt[b]++;
            end
            if (key_press == 8'h18) seen_18 = 1'b1;
        end
    end

    task automatic clear_events();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TD) @(posedge clk);
        #1;
    endtask

    // sel: 0 = press, 1 = long. Bounded poll at negedge.
    task automatic wait_evt(input int b, input int sel, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((sel == 0 && key_press[b]) || (sel == 1 && key_long[b])) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int t0;

        keys  = 8'hFF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_level", key_level, 8'hFF);
        check_val("rst_press", key_press | key_release | key_long | key_repeat, 0);
        check_val("rst_any", any_pressed, 0);
        rst_n = 1'b1;
        wait_ticks(2);

        // Single clean press on key 0
        clear_events();
        @(posedge clk); #1 keys[0] = 1'b0; t0 = cyc;
        wait_ticks(20);
        check_val("k0_press_cnt", press_cnt[0], 1);
        check_val("k0_latency_ok", int'(press_cyc[0] - t0 >= 11 && press_cyc[0] - t0 <= 14), 1);
        check_val("k0_level", key_level[0], 0);
        check_val("k0_any", any_pressed, 1);
        check_val("k0_no_rel", rel_cnt[0], 0);
        keys[0] = 1'b1;
        wait_ticks(6);
        check_val("k0_rel_cnt", rel_cnt[0], 1);
        check_val("k0_level_up", key_level[0], 1);
        check_val("k0_any_low", any_pressed, 0);

        // Bounce on key 1: toggle every tick, never stable for 3 samples
        clear_events();
        for (int i = 0; i < 8; i++) begin
            keys[1] = ~keys[1];
            repeat (TD) @(posedge clk);
            #1;
        end
        keys[1] = 1'b1;
        wait_ticks(6);
        check_val("k1_events", press_cnt[1] + rel_cnt[1] + long_cnt[1] + rpt_cnt[1], 0);
        check_val("k1_level", key_level[1], 1);

        // Long hold on key 2
        clear_events();
        keys[2] = 1'b0;
        wait_evt(2, 0, found);
        check_val("k2_press_seen", found, 1);
        repeat (30 * TD) @(posedge clk);
        #1 keys[2] = 1'b1;
        wait_ticks(6);
        check_val("k2_long_cnt", long_cnt[2], 1);
        check_val("k2_long_dt", long_cyc[2] - press_cyc[2], 10 * TD);
        check_val("k2_rpt_cnt", rpt_cnt[2], 5);
        check_val("k2_rpt_first_dt", first_rpt_cyc[2] - press_cyc[2], 14 * TD);
        check_val("k2_rpt_last_dt", last_rpt_cyc[2] - press_cyc[2], 30 * TD);
        check_val("k2_rel_cnt", rel_cnt[2], 1);
        check_val("k2_no_both", both_cnt[2], 0);

        // Simultaneous press of keys 3 and 4
        clear_events();
        keys[4:3] = 2'b00;
        wait_ticks(6);
        check_val("k34_seen_18", seen_18, 1);
        check_val("k3_press_cnt", press_cnt[3], 1);
        check_val("k4_press_cnt", press_cnt[4], 1);
        check_val("k34_same_cyc", press_cyc[3] - press_cyc[4], 0);
        keys[4:3] = 2'b11;
        wait_ticks(6);

        // Reset while key 5 is in HOLD
        clear_events();
        keys[5] = 1'b0;
        wait_evt(5, 1, found);
        check_val("k5_long_seen", found, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_val("k5_rst_level", key_level, 8'hFF);
        check_val("k5_rst_pulses", key_press | key_release | key_long | key_repeat, 0);
        check_val("k5_rst_any", any_pressed, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_events();
        wait_ticks(16);
        check_val("k5_press_cnt", press_cnt[5], 1);
        check_val("k5_long_cnt", long_cnt[5], 1);
        check_val("k5_long_dt", long_cyc[5] - press_cyc[5], 10 * TD);
        check_val("k5_no_rel", rel_cnt[5], 0);
        keys[5] = 1'b1;
        wait_ticks(6);

        // Key 6 released so the release lands on hold tick 10
        clear_events();
        keys[6] = 1'b0;
        wait_evt(6, 0, found);
        check_val("k6_press_seen", found, 1);
        repeat (29) @(posedge clk);
        #1 keys[6] = 1'b1;
        wait_ticks(6);
        check_val("k6_rel_cnt", rel_cnt[6], 1);
        check_val("k6_rel_dt", rel_cyc[6] - press_cyc[6], 10 * TD);
        check_val("k6_no_long", long_cnt[6] + rpt_cnt[6], 0);
        check_val("final_level", key_level, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
